// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: types and constants shared by the hazard unit and the ALU operand muxes.
// Revision 1.0
`default_nettype none

package cpu_pipe_pkg;

  localparam int REG_W = 5;

  // One in-flight producer: destination, writes-register, is-a-load.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // Operand-mux select encoding, one-hot as {alu_alu, bypass_alu, dmem_alu}.
  localparam logic [2:0] FWD_NONE    = 3'b000;
  localparam logic [2:0] FWD_ALU_ALU = 3'b100;
  localparam logic [2:0] FWD_BYPASS  = 3'b010;
  localparam logic [2:0] FWD_DMEM    = 3'b001;

  // Register 0 is hardwired, so a write to it never produces a match.
  function automatic logic slot_hits(input slot_t s, input logic [REG_W-1:0] rs);
    return s.wr && (s.rd != '0) && (s.rd == rs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_src_cmp.sv
// fwd_src_cmp: compares one decode source against the ALU- and memory-stage producers.
// Revision 1.0
`default_nettype none

module fwd_src_cmp
  import cpu_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             use_rs,
  input  slot_t            slot_a,
  input  slot_t            slot_b,
  output logic             m_a,
  output logic             m_b,
  output logic             load_hit,
  output logic             alu_alu_next,
  output logic             bypass_next,
  output logic             dmem_next
);

  logic [2:0] sel;

  assign m_a      = use_rs && slot_hits(slot_a, rs);
  assign m_b      = use_rs && slot_hits(slot_b, rs);
  assign load_hit = m_a && slot_a.ld;

  // The younger producer holds the newest value, so A beats B.
  always_comb begin
    sel = FWD_NONE;
    if (m_a) begin
      sel = FWD_ALU_ALU;
    end else if (m_b && slot_b.ld) begin
      sel = FWD_DMEM;
    end else if (m_b) begin
      sel = FWD_BYPASS;
    end
  end

  assign {alu_alu_next, bypass_next, dmem_next} = sel;

endmodule

`default_nettype wire

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: operand-bypass select generation, load-use stall and stall counter.
// Revision 1.0
`default_nettype none

module forward_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_wr,
  input  logic             id_mem_rd,
  output logic             alu_alu_s1,
  output logic             bypass_alu1,
  output logic             dmem_alu1,
  output logic             alu_alu_s2,
  output logic             bypass_alu2,
  output logic             dmem_alu2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  import cpu_pipe_pkg::*;

  slot_t slot_a;
  slot_t slot_b;
  slot_t slot_in;

  logic m_a1, m_b1, hit1, alu1_n, byp1_n, dmem1_n;
  logic m_a2, m_b2, hit2, alu2_n, byp2_n, dmem2_n;

  fwd_src_cmp u_cmp1 (
    .rs           (id_rs1),
    .use_rs       (id_use_rs1),
    .slot_a       (slot_a),
    .slot_b       (slot_b),
    .m_a          (m_a1),
    .m_b          (m_b1),
    .load_hit     (hit1),
    .alu_alu_next (alu1_n),
    .bypass_next  (byp1_n),
    .dmem_next    (dmem1_n)
  );

  fwd_src_cmp u_cmp2 (
    .rs           (id_rs2),
    .use_rs       (id_use_rs2),
    .slot_a       (slot_a),
    .slot_b       (slot_b),
    .m_a          (m_a2),
    .m_b          (m_b2),
    .load_hit     (hit2),
    .alu_alu_next (alu2_n),
    .bypass_next  (byp2_n),
    .dmem_next    (dmem2_n)
  );

  assign stall   = id_valid && (hit1 || hit2);
  // An invalid decode slot enters the ALU stage as a bubble.
  assign slot_in = {id_rd, id_reg_wr & id_valid, id_mem_rd & id_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_a      <= SLOT_EMPTY;
      slot_b      <= SLOT_EMPTY;
      alu_alu_s1  <= 1'b0;
      bypass_alu1 <= 1'b0;
      dmem_alu1   <= 1'b0;
      alu_alu_s2  <= 1'b0;
      bypass_alu2 <= 1'b0;
      dmem_alu2   <= 1'b0;
      stall_count <= '0;
    end else if (!hold) begin
      slot_b <= slot_a;
      if (stall) begin
        slot_a      <= SLOT_EMPTY;
        alu_alu_s1  <= 1'b0;
        bypass_alu1 <= 1'b0;
        dmem_alu1   <= 1'b0;
        alu_alu_s2  <= 1'b0;
        bypass_alu2 <= 1'b0;
        dmem_alu2   <= 1'b0;
        if (stall_count != {CNT_W{1'b1}}) begin
          stall_count <= stall_count + 1'b1;
        end
      end else begin
        slot_a      <= slot_in;
        alu_alu_s1  <= alu1_n;
        bypass_alu1 <= byp1_n;
        dmem_alu1   <= dmem1_n;
        alu_alu_s2  <= alu2_n;
        bypass_alu2 <= byp2_n;
        dmem_alu2   <= dmem2_n;
      end
    end
  end

  // A select fires exactly when some producer matches the source.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((m_a1 || m_b1) == (alu1_n || byp1_n || dmem1_n));
      assert ((m_a2 || m_b2) == (alu2_n || byp2_n || dmem2_n));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed scenarios plus randomized traffic against a reference model.
// Revision 1.0
`default_nettype none

module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        reset, hold, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_wr, id_mem_rd;
  logic        alu_alu_s1, bypass_alu1, dmem_alu1;
  logic        alu_alu_s2, bypass_alu2, dmem_alu2;
  logic        stall;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  forward_hazard_unit #(.REG_W(5), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_wr   (id_reg_wr),
    .id_mem_rd   (id_mem_rd),
    .alu_alu_s1  (alu_alu_s1),
    .bypass_alu1 (bypass_alu1),
    .dmem_alu1   (dmem_alu1),
    .alu_alu_s2  (alu_alu_s2),
    .bypass_alu2 (bypass_alu2),
    .dmem_alu2   (dmem_alu2),
    .stall       (stall),
    .stall_count (stall_count)
  );

  wire [2:0] o1 = {alu_alu_s1, bypass_alu1, dmem_alu1};
  wire [2:0] o2 = {alu_alu_s2, bypass_alu2, dmem_alu2};

  int total = 0;
  int bad   = 0;

  // Reference model: the two older instructions as a tiny history array, [0] = ALU, [1] = MEM.
  logic [4:0]  h_rd [2];
  bit          h_wr [2];
  bit          h_ld [2];
  logic [2:0]  e1, e2;
  logic [31:0] ecnt;

  function automatic bit writes(int age, logic [4:0] rs);
    return h_wr[age] && rs != 5'd0 && h_rd[age] == rs;
  endfunction

  function automatic logic [2:0] want_sel(logic [4:0] rs, bit used);
    if (!used)        return 3'b000;
    if (writes(0, rs)) return 3'b100;
    if (writes(1, rs)) return h_ld[1] ? 3'b001 : 3'b010;
    return 3'b000;
  endfunction

  function automatic bit want_stall();
    return id_valid && ((id_use_rs1 && writes(0, id_rs1) && h_ld[0]) ||
                        (id_use_rs2 && writes(0, id_rs2) && h_ld[0]));
  endfunction

  task automatic set_in(bit v, logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2,
                        logic [4:0] rd, bit wr, bit ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_wr = wr; id_mem_rd = ld;
  endtask

  task automatic tick(bit r, bit h);
    bit         st;
    logic [2:0] n1, n2;
    reset = r; hold = h;
    st = want_stall();
    n1 = want_sel(id_rs1, id_use_rs1);
    n2 = want_sel(id_rs2, id_use_rs2);
    @(posedge clk);
    if (r) begin
      h_rd = '{5'd0, 5'd0}; h_wr = '{0, 0}; h_ld = '{0, 0};
      e1 = 3'b000; e2 = 3'b000; ecnt = 32'd0;
    end else if (!h) begin
      h_rd[1] = h_rd[0]; h_wr[1] = h_wr[0]; h_ld[1] = h_ld[0];
      if (st) begin
        h_rd[0] = 5'd0; h_wr[0] = 0; h_ld[0] = 0;
        e1 = 3'b000; e2 = 3'b000;
        if (ecnt != 32'hFFFF_FFFF) ecnt = ecnt + 32'd1;
      end else begin
        h_rd[0] = id_rd; h_wr[0] = id_reg_wr && id_valid; h_ld[0] = id_mem_rd && id_valid;
        e1 = n1; e2 = n2;
      end
    end
    #1;
    reset = 1'b0; hold = 1'b0;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      set_in($urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1), 5'($urandom),
             $urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
      tick(1, $urandom_range(0, 1));
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if ({o1, o2} !== 6'b0) begin bad++; $display("FAIL reset_sel got=%b exp=000000", {o1, o2}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_count); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_in(1, 1, 1, 2, 1, 3, 1, 0); tick(0, 0);
    set_in(1, 9, 1, 3, 1, 4, 1, 0); tick(0, 0);
    total++; if ({o1, o2} !== 6'b000_100) begin bad++; $display("FAIL alu_fwd got=%b exp=000100", {o1, o2}); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_in(1, 1, 1, 2, 1, 3, 1, 0);  tick(0, 0);
    set_in(1, 8, 1, 9, 1, 10, 1, 0); tick(0, 0);
    set_in(1, 3, 1, 11, 1, 12, 1, 0); tick(0, 0);
    total++; if ({o1, o2} !== 6'b010_000) begin bad++; $display("FAIL bypass got=%b exp=010000", {o1, o2}); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 1, 1, 0, 0, 5, 1, 1); tick(0, 0);
    set_in(1, 5, 1, 5, 1, 9, 1, 0); #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick(0, 0); #1;
    total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_count); end
    total++; if ({o1, o2} !== 6'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=000000", {o1, o2}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got=%b exp=0", stall); end
    tick(0, 0);
    total++; if ({o1, o2} !== 6'b001_001) begin bad++; $display("FAIL lu_dmem got=%b exp=001001", {o1, o2}); end
    total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=1", stall_count); end
  endtask

  task automatic test_reg0_priority();
    do_reset();
    set_in(1, 1, 1, 2, 1, 0, 1, 1); tick(0, 0);
    set_in(1, 0, 1, 0, 1, 6, 1, 0); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall); end
    tick(0, 0);
    total++; if ({o1, o2} !== 6'b0) begin bad++; $display("FAIL r0_sel got=%b exp=000000", {o1, o2}); end
    do_reset();
    set_in(1, 1, 1, 2, 1, 7, 1, 1); tick(0, 0);
    set_in(1, 1, 1, 2, 0, 7, 1, 0); tick(0, 0);
    set_in(1, 7, 0, 7, 1, 8, 1, 0); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL prio_stall got=%b exp=0", stall); end
    tick(0, 0);
    total++; if ({o1, o2} !== 6'b000_100) begin bad++; $display("FAIL prio_sel got=%b exp=000100", {o1, o2}); end
  endtask

  task automatic test_hold_reset_stall();
    do_reset();
    set_in(1, 1, 1, 2, 1, 5, 1, 1); tick(0, 0);
    set_in(1, 5, 1, 3, 1, 9, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1);
      total++; if (stall !== 1'b1 || stall_count !== 32'd0) begin
        bad++; $display("FAIL hold_%0d stall=%b cnt=%0d exp stall=1 cnt=0", i, stall, stall_count);
      end
    end
    tick(0, 0);
    total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL hold_release got=%0d exp=1", stall_count); end
    set_in(1, 1, 1, 2, 1, 6, 1, 1); tick(0, 0);
    set_in(1, 6, 1, 6, 1, 9, 1, 0); #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall got=%b exp=1", stall); end
    tick(1, 0);
    total++; if ({o1, o2} !== 6'b0 || stall_count !== 32'd0 || stall !== 1'b0) begin
      bad++; $display("FAIL rst_in_stall sel=%b cnt=%0d stall=%b exp 000000/0/0", {o1, o2}, stall_count, stall);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1),
             5'($urandom_range(0, 7)), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      #1;
      total++; if (stall !== want_stall()) begin
        bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, want_stall());
      end
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
      total++; if (o1 !== e1 || o2 !== e2) begin
        bad++; $display("FAIL rnd_sel cyc=%0d got=%b/%b exp=%b/%b", i, o1, o2, e1, e2);
      end
      total++; if (stall_count !== ecnt) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_count, ecnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    h_rd = '{5'd0, 5'd0}; h_wr = '{0, 0}; h_ld = '{0, 0};
    e1 = 3'b000; e2 = 3'b000; ecnt = 32'd0;
    @(negedge clk);
    test_reset();
    test_alu_fwd();
    test_bypass();
    test_load_use();
    test_reg0_priority();
    test_hold_reset_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Forwarding and load-use hazard controller for the 32-bit pipelined CPU. It tracks the destination registers of the two instructions ahead of decode and produces the registered operand-bypass selects (`alu_alu_sN`, `bypass_aluN`, `dmem_aluN`) consumed by the ALU operand muxes one stage downstream. It detects load-use hazards, stalls decode for exactly one cycle, and injects a bubble. It also keeps a saturating count of stall cycles for performance monitoring.

## Interface
Parameters:
- `REG_W`, 5: register-index width.
- `CNT_W`, 32: stall-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hold`  in  1  global pipeline freeze; all internal state holds.
- `id_valid`  in  1  the decode-stage instruction is real.
- `id_rs1`, `id_rs2`  in  REG_W  decode source registers.
- `id_use_rs1`, `id_use_rs2`  in  1  the instruction reads the corresponding source.
- `id_rd`  in  REG_W  decode destination register.
- `id_reg_wr`  in  1  the instruction writes `id_rd`.
- `id_mem_rd`  in  1  the instruction is a load.
- `alu_alu_s1`, `bypass_alu1`, `dmem_alu1`  out  1  operand-1 selects (registered).
- `alu_alu_s2`, `bypass_alu2`, `dmem_alu2`  out  1  operand-2 selects (registered).
- `stall`  out  1  hold fetch/decode this cycle (combinational).
- `stall_count`  out  CNT_W  number of stall cycles taken (registered).

## Operation
Internal state is held in two producer slots, each holding `{rd, wr, ld}`:
- Slot A is the instruction one older than decode, now in the ALU stage.
- Slot B is the instruction two older, now in the memory stage.
- A slot with `wr=0` or `rd=0` never matches. Register 0 is never forwarded.

Match rules, per source N where `id_use_rsN` is 1:
- `mA` = A.wr and A.rd == rsN.
- `mB` = B.wr and B.rd == rsN.

Load-use hazard:
- `stall` = id_valid and (source 1 matches A with A.ld, or source 2 matches A with A.ld).

Edge update when `hold`=0 and `stall`=0:
- B <= A.
- A <= {id_rd, id_reg_wr & id_valid, id_mem_rd & id_valid}.
- Selects for each source, in priority order:
  - mA gives `alu_alu_sN`=1.
  - Otherwise mB with B.ld gives `dmem_aluN`=1.
  - Otherwise mB gives `bypass_aluN`=1.
  - Otherwise all three selects are 0.
- At most one select per operand is high.

Edge update when `hold`=0 and `stall`=1:
- B <= A.
- A <= bubble {0,0,0}.
- All six selects <= 0.
- `stall_count` increments, saturating at all-ones.

Edge update when `hold`=1:
- A, B, the selects and `stall_count` all hold.
- `stall` still evaluates combinationally from the held state.

## Timing
- Reset (synchronous, `reset`=1 at the edge):
  - A and B are cleared.
  - All six selects are 0.
  - `stall_count` is 0.
  - `stall` is 0 after reset, because the slots are empty.
  - `reset` overrides `hold`.
  - A reset during a stall cancels the stall; no bubble is counted.
- Select latency: one cycle. Selects computed from decode in cycle t are valid in cycle t+1, when that instruction occupies the ALU stage.
- Stall latency: zero cycles, combinational from the decode inputs and slot A.
  - A load-use stall lasts exactly one cycle, because the load then moves to B.
  - The following cycle selects `dmem_aluN` for the stalled consumer.
- Simultaneous matches:
  - Source 1 and source 2 are resolved independently and may both be high (for example, both sources equal the same rd).
  - When A and B write the same rd, A wins.
- Any `id_valid`=0 cycle enters slot A as a bubble.

## Structure
- Shared package `cpu_pipe_pkg` holds:
  - `REG_W`.
  - the slot typedef `{rd, wr, ld}`.
  - the forward-select encoding constants shared with the operand muxes.
- Sub-module `fwd_src_cmp`, instantiated twice (once per source). It takes one source index plus slots A and B, and returns `mA`, `mB`, `load_hit` and the three next-state selects.
- The top level holds the slot registers, the select registers, the stall logic and the counter.

## Test plan
- Reset held for 2 cycles with random inputs: all selects 0, `stall`=0, `stall_count`=0.
- ALU op writing r3, then next-cycle op with rs2=r3: `alu_alu_s2`=1 one cycle later; all other selects 0.
- Writer of r3, an unrelated op, then a consumer with rs1=r3: `bypass_alu1`=1.
- Load to r5, then a consumer with rs1=r5 and rs2=r5:
  - `stall`=1 for exactly one cycle and `stall_count`=1.
  - The next cycle, `dmem_alu1`=`dmem_alu2`=1.
- Register-0 and priority cases:
  - A writer with rd=0 produces no select.
  - A and B both writing r7, consumer rs2=r7: only `alu_alu_s2`=1.
- Hold and reset during a stall:
  - Load-use stall with `hold`=1 for 3 cycles: `stall` stays 1 and `stall_count` stays unchanged.
  - Releasing `hold` then increments `stall_count` by 1.
  - Asserting `reset` during a stall clears everything the following cycle.
